// File: rtl/popcount_window_if.sv
// popcount_window_if
// Handshake bundle for popcount_window.
//   Input side : in_valid/in_ready handshake carrying in_data (WIDTH bits),
//                in_last (close window early), mode (2-bit compare select)
//                and target (CW-bit compare operand).
//   Output side: out_valid/out_ready handshake carrying out_count (CW),
//                out_words (WW) and out_match.
// Modports:
//   master - the producer/consumer around the block (drives inputs, out_ready)
//   slave  - the popcount_window block itself
interface popcount_window_if #(
    parameter int WIDTH  = 7,
    parameter int WINDOW = 4
);
    localparam int CW = $clog2(WIDTH * WINDOW + 1);
    localparam int WW = $clog2(WINDOW + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [1:0]       mode;
    logic [CW-1:0]    target;

    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic [WW-1:0]    out_words;
    logic             out_match;

    modport master (
        output in_valid, in_data, in_last, mode, target, out_ready,
        input  in_ready, out_valid, out_count, out_words, out_match
    );

    modport slave (
        input  in_valid, in_data, in_last, mode, target, out_ready,
        output in_ready, out_valid, out_count, out_words, out_match
    );
endinterface

// File: rtl/popcount_window.sv
// popcount_window
// Streaming ones-counter. Sums the set bits of up to WINDOW input words
// (fewer if in_last closes the window early) and presents the total, the
// number of beats and a mode-selected compare flag as a registered result.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - popcount_window_if.slave (input and output handshakes)
// Compare modes: 00 count==target, 01 count>=target, 10 count<=target,
//                11 count is odd.
module popcount_window #(
    parameter int WIDTH  = 7,
    parameter int WINDOW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    popcount_window_if.slave     bus
);
    localparam int CW = $clog2(WIDTH * WINDOW + 1);
    localparam int WW = $clog2(WINDOW + 1);

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        MODE_EQ  = 2'b00,
        MODE_GE  = 2'b01,
        MODE_LE  = 2'b10,
        MODE_ODD = 2'b11
    } mode_t;

    state_t        state;
    logic [CW-1:0] acc;
    logic [WW-1:0] wcnt;

    logic          res_valid;
    logic [CW-1:0] res_count;
    logic [WW-1:0] res_words;
    logic          res_match;

    logic [CW-1:0] pc;
    logic [CW-1:0] sum;
    logic [WW-1:0] wcnt_inc;
    logic          beat;
    logic          completing;
    logic          match_next;

    function automatic logic compare(input logic [CW-1:0] count,
                                     input logic [CW-1:0] tgt,
                                     input mode_t         md);
        logic r;
        r = 1'b0;
        case (md)
            MODE_EQ:  r = (count == tgt);
            MODE_GE:  r = (count >= tgt);
            MODE_LE:  r = (count <= tgt);
            MODE_ODD: r = count[0];
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pc = pc + CW'(bus.in_data[i]);
        end
    end

    // In HOLD the accepting side is only open while the result drains,
    // which is what gives back-to-back windows with no bubble.
    assign bus.in_ready = (state == ACC) || bus.out_ready;
    assign beat         = bus.in_valid && bus.in_ready;
    assign completing   = (wcnt == WW'(WINDOW - 1)) || bus.in_last;

    // acc cannot overflow: it holds at most WIDTH*(WINDOW-1) before the add.
    assign sum          = acc + pc;
    assign wcnt_inc     = wcnt + WW'(1);
    assign match_next   = compare(sum, bus.target, mode_t'(bus.mode));

    // acc/wcnt are always zero while in HOLD, so the same sum/wcnt_inc
    // datapath serves a beat accepted in either state: a completing beat
    // loads a new result (staying in HOLD), a non-completing beat seeds the
    // next window with acc=pc, wcnt=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            wcnt      <= '0;
            res_valid <= 1'b0;
            res_count <= '0;
            res_words <= '0;
            res_match <= 1'b0;
        end else if (beat && completing) begin
            res_count <= sum;
            res_words <= wcnt_inc;
            res_match <= match_next;
            res_valid <= 1'b1;
            acc       <= '0;
            wcnt      <= '0;
            state     <= HOLD;
        end else begin
            if (beat) begin
                acc  <= sum;
                wcnt <= wcnt_inc;
            end
            if (state == HOLD && bus.out_ready) begin
                res_valid <= 1'b0;
                state     <= ACC;
            end
        end
    end

    assign bus.out_valid = res_valid;
    assign bus.out_count = res_count;
    assign bus.out_words = res_words;
    assign bus.out_match = res_match;
endmodule

// File: tb/tb_popcount_window.sv
// tb_popcount_window
// Directed bench for popcount_window: a WINDOW=4 instance and a WINDOW=1
// instance. Expected results are queued when a window is issued; a monitor
// pops and compares on every output handshake.
module tb_popcount_window;
    localparam int M_EQ  = 0;
    localparam int M_GE  = 1;
    localparam int M_LE  = 2;
    localparam int M_ODD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    popcount_window_if #(.WIDTH(7), .WINDOW(4)) b4();
    popcount_window_if #(.WIDTH(7), .WINDOW(1)) b1();

    popcount_window #(.WIDTH(7), .WINDOW(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    popcount_window #(.WIDTH(7), .WINDOW(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    typedef struct {
        int count;
        int words;
        int match;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int sel, input int count, input int words, input int match);
        exp_t e;
        e.count = count;
        e.words = words;
        e.match = match;
        if (sel == 0) q4.push_back(e);
        else          q1.push_back(e);
    endtask

    // Drives one beat, waits (bounded) for in_ready, returns the number of
    // cycles spent waiting. Leaves time at posedge+1 with in_valid low.
    task automatic send(input int sel, input int data, input bit last,
                        input int md, input int tgt, output int waits);
        bit ok;
        waits = 0;
        ok    = 1'b0;
        if (sel == 0) begin
            b4.in_valid = 1'b1;
            b4.in_data  = 7'(data);
            b4.in_last  = last;
            b4.mode     = 2'(md);
            b4.target   = 5'(tgt);
        end else begin
            b1.in_valid = 1'b1;
            b1.in_data  = 7'(data);
            b1.in_last  = last;
            b1.mode     = 2'(md);
            b1.target   = 3'(tgt);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((sel == 0) ? b4.in_ready : b1.in_ready) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, expected high", waits);
        end
        @(posedge clk);
        #1;
        if (sel == 0) b4.in_valid = 1'b0;
        else          b1.in_valid = 1'b0;
    endtask

    task automatic win4(input int d0, input int d1, input int d2, input int d3,
                        input int md, input int tgt,
                        input int count, input int match);
        int w;
        push(0, count, 4, match);
        send(0, d0, 1'b0, md, tgt, w);
        send(0, d1, 1'b0, md, tgt, w);
        send(0, d2, 1'b0, md, tgt, w);
        send(0, d3, 1'b0, md, tgt, w);
    endtask

    // Scoreboard monitor: compares on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (b4.out_valid && b4.out_ready) begin
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut4_unexpected: got result count=%0d, expected none", b4.out_count);
                end else begin
                    e = q4.pop_front();
                    check("dut4_count", int'(b4.out_count), e.count);
                    check("dut4_words", int'(b4.out_words), e.words);
                    check("dut4_match", int'(b4.out_match), e.match);
                end
            end
            if (b1.out_valid && b1.out_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut1_unexpected: got result count=%0d, expected none", b1.out_count);
                end else begin
                    e = q1.pop_front();
                    check("dut1_count", int'(b1.out_count), e.count);
                    check("dut1_words", int'(b1.out_words), e.words);
                    check("dut1_match", int'(b1.out_match), e.match);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int w;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_last = 1'b0;
        b4.mode = '0; b4.target = '0; b4.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0;
        b1.mode = '0; b1.target = '0; b1.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", int'(b4.out_valid), 0);
        check("rst_out_count", int'(b4.out_count), 0);
        check("rst_out_words", int'(b4.out_words), 0);
        check("rst_out_match", int'(b4.out_match), 0);
        check("rst_in_ready",  int'(b4.in_ready),  1);
        @(posedge clk); #1;

        // Full window, EQ 10: 7+0+1+2 = 10
        win4('h7F, 'h00, 'h01, 'h03, M_EQ, 10, 10, 1);
        @(negedge clk);
        check("t1_latency_valid", int'(b4.out_valid), 1);
        @(negedge clk);
        check("t1_valid_drop", int'(b4.out_valid), 0);
        @(posedge clk); #1;

        // Early close: 4+3 = 7, GE 8 -> 0
        push(0, 7, 2, 0);
        send(0, 'h0F, 1'b0, M_GE, 8, w);
        send(0, 'h70, 1'b1, M_GE, 8, w);
        repeat (2) @(posedge clk); #1;

        // Backpressure: 7+7+0+1 = 15, EQ 15 -> 1
        b4.out_ready = 1'b0;
        win4('h7F, 'h7F, 'h00, 'h01, M_EQ, 15, 15, 1);
        b4.in_valid = 1'b1;
        b4.in_data  = 7'h7F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(b4.out_valid), 1);
            check("bp_in_ready",  int'(b4.in_ready),  0);
            check("bp_out_count", int'(b4.out_count), 15);
            check("bp_out_words", int'(b4.out_words), 4);
            check("bp_out_match", int'(b4.out_match), 1);
        end
        @(posedge clk); #1;
        b4.out_ready = 1'b1;
        // New window seeded by the handshake beat: 1+2+0+3 = 6, odd -> 0
        push(0, 6, 4, 0);
        send(0, 'h01, 1'b0, M_ODD, 0, w);
        check("bp_resume_wait", w, 0);
        send(0, 'h03, 1'b0, M_ODD, 0, w);
        send(0, 'h00, 1'b0, M_ODD, 0, w);
        send(0, 'h07, 1'b0, M_ODD, 0, w);

        // Compare modes on count = 5, back to back
        win4('h1F, 0, 0, 0, M_LE,  5, 5, 1);
        win4('h1F, 0, 0, 0, M_ODD, 0, 5, 1);
        win4('h1F, 0, 0, 0, M_EQ,  4, 5, 0);
        win4('h1F, 0, 0, 0, M_GE,  6, 5, 0);
        repeat (2) @(posedge clk); #1;

        // Reset mid-window: partial window discarded, held result cleared
        send(0, 'h7F, 1'b0, M_EQ, 0, w);
        send(0, 'h7F, 1'b0, M_EQ, 0, w);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(b4.out_valid), 0);
        check("arst_out_count", int'(b4.out_count), 0);
        check("arst_out_words", int'(b4.out_words), 0);
        check("arst_out_match", int'(b4.out_match), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        win4('h01, 'h01, 'h01, 'h01, M_EQ, 4, 4, 1);
        repeat (2) @(posedge clk); #1;

        // WINDOW=1: every beat completes, no bubble
        push(1, 2, 1, 0);
        push(1, 3, 1, 1);
        push(1, 7, 1, 1);
        send(1, 'h03, 1'b0, M_ODD, 0, w);
        check("w1_ready_0", w, 0);
        send(1, 'h07, 1'b0, M_ODD, 0, w);
        check("w1_ready_1", w, 0);
        send(1, 'h7F, 1'b0, M_ODD, 0, w);
        check("w1_ready_2", w, 0);
        repeat (3) @(posedge clk); #1;

        check("q4_drained", q4.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/popcount_window.md
# popcount_window

Streaming, parametrised ones-counter for the prelab datapath. It accepts WIDTH-bit words over a valid/ready handshake and sums their set bits across a window of up to WINDOW words. At the end of each window it presents the total, the beat count and a mode-selected compare flag on a registered valid/ready output. It generalises the fixed 7-bit count-and-select pair into a sequential, back-pressured block with selectable compare modes.

## Interface
- WIDTH, 7, bits per input word (>=1)
- WINDOW, 4, maximum words per window (>=1)
- CW (localparam), $clog2(WIDTH*WINDOW+1), count width
- WW (localparam), $clog2(WINDOW+1), beat-count width
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  word to count
- in_last  input  1  current beat closes the window early
- mode  input  2  compare mode: 00 EQ, 01 GE, 10 LE, 11 ODD parity
- target  input  CW  compare operand
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_count  output  CW  ones in the window
- out_words  output  WW  beats in the window (1..WINDOW)
- out_match  output  1  compare result

## Operation
- Beat accepted when in_valid && in_ready. pc = popcount(in_data), zero-extended to CW bits.
- Internal state: acc (CW), wcnt (WW), FSM {ACC, HOLD}.
- ACC: in_ready=1, out_valid=0. A beat updates acc += pc and wcnt += 1. A beat is completing when wcnt==WINDOW-1 or in_last=1.
- On a completing beat:
  - out_count <= acc+pc and out_words <= wcnt+1.
  - out_match is computed from mode/target sampled on that beat: EQ (count==target), GE (count>=target), LE (count<=target), ODD (count[0]).
  - acc and wcnt clear; FSM goes to HOLD.
- HOLD: out_valid=1; in_ready = out_ready (combinational); out_* held stable while out_ready=0.
  - Handshake with no accepted beat: go to ACC.
  - Handshake plus a non-completing beat: go to ACC with acc=pc, wcnt=1.
  - Handshake plus a completing beat (e.g. WINDOW=1 or in_last): stay in HOLD and load the new result.
- in_valid without in_ready: no state change. in_data, in_last, mode and target are don't-care when no beat is accepted.
- in_last on the WINDOW-th beat is redundant and gives the same result.
- No overflow is possible: CW covers WIDTH*WINDOW.

## Timing
- Reset (async assert, sync release to clk) clears everything: FSM=ACC, acc=0, wcnt=0, out_valid=0, out_count=0, out_words=0, out_match=0, in_ready=1 from the first cycle after release.
- Reset mid-window or mid-HOLD discards the partial window or pending result.
- Latency: out_valid rises on the clock edge that accepts the completing beat, i.e. visible the cycle after that beat.
- Throughput: one word per cycle sustained when out_ready=1, including at window boundaries (no bubble).
- out_* outputs are registered; in_ready is the only combinational output (depends on FSM and out_ready).
- mode and target changes take effect only at the next completing beat.

## Test plan
- WIDTH=7, WINDOW=4, out_ready=1, mode=EQ, target=10; beats 7'h7F, 7'h00, 7'h01, 7'h03 -> out_valid one cycle after the 4th beat; out_count=10, out_words=4, out_match=1; out_valid low the next cycle.
- Early close: beats 7'h0F then 7'h70 with in_last=1, mode=GE, target=8 -> out_count=7, out_words=2, out_match=0.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_valid=1 and out_* stable, in_ready=0, in_valid beats ignored. Raise out_ready with beat 7'h01 valid -> handshake completes and the next window starts with acc=1, wcnt=1.
- Modes on count=5 (beats 7'h1F, 0, 0, 0): LE target=5 -> match 1; ODD -> match 1; EQ target=4 -> match 0; GE target=6 -> match 0.
- Reset: rst_n low asynchronously after 2 beats (7'h7F, 7'h7F), then release; send 4 beats of 7'h01 -> out_count=4, out_words=4; all outputs 0 during reset.
- WINDOW=1: 3 back-to-back beats 7'h03, 7'h07, 7'h7F with out_ready=1 -> in_ready stays 1; out_count 2, 3, 7 on consecutive cycles; out_words=1 each.
